// File: rtl/net_pkg.sv
// Shared network-stack definitions: TX buffer geometry and the TX arbiter
// state encoding (also used by net_top).
package net_pkg;

    localparam int ETH_MTU = 1518;
    localparam int ADDR_W  = 11;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT_AVAIL,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// MAC-side bundle of the TX arbiter: packet buffer write port plus the
// mac_tx_ifc length / doorbell / available handshake.
interface tx_arbiter_if;
    import net_pkg::*;

    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_wdata;
    logic [ADDR_W-1:0] tx_maxaddr;
    logic              tx_doorbell;
    logic              tx_available;

    // arbiter side
    modport master (
        output buf_we, buf_addr, buf_wdata, tx_maxaddr, tx_doorbell,
        input  tx_available
    );

    // buffer / mac_tx_ifc side
    modport slave (
        input  buf_we, buf_addr, buf_wdata, tx_maxaddr, tx_doorbell,
        output tx_available
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first asserted request at or after
// rr+1 (mod N), returned one-hot and as an index.
module rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] rr_i,
    output logic [N-1:0]     pick_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] j;

    // Walk from the farthest candidate back to the nearest so the nearest
    // asserted request after rr is the last one written.
    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        j      = '0;
        for (int k = N; k >= 1; k--) begin
            j = IDX_W'((int'(rr_i) + k) % N);
            if (req_i[j]) begin
                pick_o    = '0;
                pick_o[j] = 1'b1;
                idx_o     = j;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/tx_arbiter.sv
// TX arbiter: shares the single TX packet buffer and the mac_tx_ifc
// doorbell between N_REQ producers, round-robin, one packet at a time.
module tx_arbiter import net_pkg::*; #(
    parameter int N_REQ         = 3,
    parameter int GRANT_TIMEOUT = 4096,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req,
    output logic [N_REQ-1:0]        grant,
    input  logic [N_REQ-1:0]        wr_en,
    input  logic [N_REQ*ADDR_W-1:0] wr_addr,
    input  logic [N_REQ*8-1:0]      wr_data,
    input  logic [N_REQ-1:0]        commit,
    input  logic [N_REQ*ADDR_W-1:0] commit_len,
    output logic [N_REQ-1:0]        sent,
    output logic [N_REQ-1:0]        dropped,
    tx_arbiter_if.master            mac
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(max_int(GRANT_TIMEOUT, ACK_TIMEOUT)) + 1;
    localparam logic [TMR_W-1:0]  GT_LAST = TMR_W'(GRANT_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  AT_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] MTU_L   = ADDR_W'(ETH_MTU);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              buf_we_q, buf_we_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_wdata_q, buf_wdata_d;
    logic [ADDR_W-1:0] maxaddr_q, maxaddr_d;
    logic              doorbell_q, doorbell_d;
    logic [N_REQ-1:0]  sent_q, sent_d;
    logic [N_REQ-1:0]  dropped_q, dropped_d;
    logic              drop_fill;

    logic [N_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    logic [ADDR_W-1:0] addr_a [N_REQ];
    logic [ADDR_W-1:0] len_a  [N_REQ];
    logic [7:0]        data_a [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_a[i] = wr_addr[i*ADDR_W +: ADDR_W];
        assign len_a[i]  = commit_len[i*ADDR_W +: ADDR_W];
        assign data_a[i] = wr_data[i*8 +: 8];
    end

    rr_picker #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i  (req),
        .rr_i   (rr_q),
        .pick_o (pick_oh),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= IDX_W'(N_REQ - 1);
            owner_q     <= '0;
            timer_q     <= '0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            maxaddr_q   <= '0;
            doorbell_q  <= 1'b0;
            sent_q      <= '0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            timer_q     <= timer_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            maxaddr_q   <= maxaddr_d;
            doorbell_q  <= doorbell_d;
            sent_q      <= sent_d;
            dropped_q   <= dropped_d;
        end
    end

    // Next-state, grant bookkeeping, buffer write mux and timer.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        timer_d     = timer_q;
        buf_we_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        maxaddr_d   = maxaddr_q;
        doorbell_d  = 1'b0;
        sent_d      = '0;
        dropped_d   = '0;
        drop_fill   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    rr_d    = pick_idx;
                    owner_d = pick_idx;
                    state_d = FILL;
                end
            end
            FILL: begin
                buf_we_d    = wr_en[owner_q] && (addr_a[owner_q] < MTU_L);
                buf_addr_d  = addr_a[owner_q];
                buf_wdata_d = data_a[owner_q];
                // Commit is checked first so it beats a same-cycle timeout.
                if (commit[owner_q]) begin
                    if ((len_a[owner_q] != '0) && (len_a[owner_q] <= MTU_L)) begin
                        maxaddr_d = len_a[owner_q];
                        state_d   = WAIT_AVAIL;
                    end else begin
                        drop_fill = 1'b1;
                    end
                end else if (!req[owner_q] || (timer_q == GT_LAST)) begin
                    drop_fill = 1'b1;
                end
                if (drop_fill) begin
                    dropped_d[owner_q] = 1'b1;
                    grant_d            = '0;
                    state_d            = IDLE;
                end
            end
            WAIT_AVAIL: begin
                if (mac.tx_available) begin
                    doorbell_d = 1'b1;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // MAC never dropped available: assume it sent and move on.
                if (!mac.tx_available) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == AT_LAST) begin
                    sent_d[owner_q] = 1'b1;
                    grant_d         = '0;
                    state_d         = IDLE;
                end
            end
            WAIT_DONE: begin
                if (mac.tx_available) begin
                    sent_d[owner_q] = 1'b1;
                    grant_d         = '0;
                    state_d         = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end
    end

    assign grant           = grant_q;
    assign sent            = sent_q;
    assign dropped         = dropped_q;
    assign mac.buf_we      = buf_we_q;
    assign mac.buf_addr    = buf_addr_q;
    assign mac.buf_wdata   = buf_wdata_q;
    assign mac.tx_maxaddr  = maxaddr_q;
    assign mac.tx_doorbell = doorbell_q;

endmodule
